// File: rtl/core_pkg.sv
// Shared definitions for the RV64 core pipeline control.
// Register-index width, x0 index and hazard FSM states.
package core_pkg;

  localparam int REG_AW = 5;
  localparam int unsigned X0_IDX = 0;

  typedef enum logic {
    HZ_IDLE,
    HZ_LSTALL
  } hz_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low reset.
// Holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/hazard_ctrl_mc.sv
// Hazard controller: multi-cycle load-use stalls, EX-busy freeze,
// taken-branch flush and a saturating stall-cycle counter.
module hazard_ctrl_mc #(
  parameter int REG_AW   = core_pkg::REG_AW,
  parameter int LOAD_LAT = 1,
  parameter int PERF_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              de_memRead,
  input  logic [REG_AW-1:0] de_rd,
  input  logic [REG_AW-1:0] fd_rs1,
  input  logic [REG_AW-1:0] fd_rs2,
  input  logic              fd_useRs1,
  input  logic              fd_useRs2,
  input  logic              ex_busy,
  input  logic              ex_takeBranch,
  output logic              stall,
  output logic              pcWrite,
  output logic              fdWrite,
  output logic              deWrite,
  output logic              deBubble,
  output logic              fdFlush,
  output logic              deFlush,
  output logic [PERF_W-1:0] perfStallCycles
);

  import core_pkg::*;

  localparam int LCW = $clog2(LOAD_LAT + 1);

  hz_state_e      state_q, state_d;
  logic [LCW-1:0] lcnt_q, lcnt_d;

  logic hit;
  logic busy_c;
  logic brn_c;
  logic ld_c;

  assign hit = de_memRead
             && (de_rd != REG_AW'(X0_IDX))
             && ((fd_useRs1 && (de_rd == fd_rs1))
              || (fd_useRs2 && (de_rd == fd_rs2)));

  assign busy_c = ex_busy;
  assign brn_c  = !ex_busy && ex_takeBranch;
  assign ld_c   = !ex_busy && !ex_takeBranch
               && (hit || (state_q == HZ_LSTALL));

  always_comb begin
    state_d  = state_q;
    lcnt_d   = lcnt_q;
    stall    = 1'b0;
    pcWrite  = 1'b1;
    fdWrite  = 1'b1;
    deWrite  = 1'b1;
    deBubble = 1'b0;
    fdFlush  = 1'b0;
    deFlush  = 1'b0;
    if (!rst_n) begin
      pcWrite = 1'b0;
      fdWrite = 1'b0;
      deWrite = 1'b0;
    end else begin
      unique case (1'b1)
        busy_c: begin
          stall   = 1'b1;
          pcWrite = 1'b0;
          fdWrite = 1'b0;
          deWrite = 1'b0;
        end
        brn_c: begin
          // Redirect squashes whatever was stalled in FD.
          fdFlush = 1'b1;
          deFlush = 1'b1;
          state_d = HZ_IDLE;
          lcnt_d  = '0;
        end
        ld_c: begin
          stall    = 1'b1;
          pcWrite  = 1'b0;
          fdWrite  = 1'b0;
          deBubble = 1'b1;
          if (state_q == HZ_LSTALL) begin
            lcnt_d = lcnt_q - LCW'(1);
            if (lcnt_q == LCW'(1)) begin
              state_d = HZ_IDLE;
            end
          end else if (LOAD_LAT > 1) begin
            state_d = HZ_LSTALL;
            lcnt_d  = LCW'(LOAD_LAT - 1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HZ_IDLE;
      lcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      lcnt_q  <= lcnt_d;
    end
  end

  sat_counter #(
    .W(PERF_W)
  ) u_perf (
    .clk  (clk),
    .rst_n(rst_n),
    .inc_i(stall),
    .cnt_o(perfStallCycles)
  );

endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// Directed bench for hazard_ctrl_mc: three instances (LOAD_LAT=1,
// LOAD_LAT=3, PERF_W=4) share one stimulus bus.
module tb_hazard_ctrl_mc;

  logic       clk;
  logic       rst_n;
  logic       de_memRead;
  logic [4:0] de_rd;
  logic [4:0] fd_rs1;
  logic [4:0] fd_rs2;
  logic       fd_useRs1;
  logic       fd_useRs2;
  logic       ex_busy;
  logic       ex_takeBranch;

  logic        a_stall, a_pc, a_fd, a_de, a_bub, a_ff, a_df;
  logic [31:0] a_perf;
  logic        b_stall, b_pc, b_fd, b_de, b_bub, b_ff, b_df;
  logic [31:0] b_perf;
  logic        c_stall, c_pc, c_fd, c_de, c_bub, c_ff, c_df;
  logic [3:0]  c_perf;

  int checks;
  int errors;

  hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(1), .PERF_W(32)) u1 (
    .clk(clk), .rst_n(rst_n), .de_memRead(de_memRead), .de_rd(de_rd),
    .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_useRs1(fd_useRs1),
    .fd_useRs2(fd_useRs2), .ex_busy(ex_busy), .ex_takeBranch(ex_takeBranch),
    .stall(a_stall), .pcWrite(a_pc), .fdWrite(a_fd), .deWrite(a_de),
    .deBubble(a_bub), .fdFlush(a_ff), .deFlush(a_df),
    .perfStallCycles(a_perf)
  );

  hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(3), .PERF_W(32)) u3 (
    .clk(clk), .rst_n(rst_n), .de_memRead(de_memRead), .de_rd(de_rd),
    .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_useRs1(fd_useRs1),
    .fd_useRs2(fd_useRs2), .ex_busy(ex_busy), .ex_takeBranch(ex_takeBranch),
    .stall(b_stall), .pcWrite(b_pc), .fdWrite(b_fd), .deWrite(b_de),
    .deBubble(b_bub), .fdFlush(b_ff), .deFlush(b_df),
    .perfStallCycles(b_perf)
  );

  hazard_ctrl_mc #(.REG_AW(5), .LOAD_LAT(1), .PERF_W(4)) u4 (
    .clk(clk), .rst_n(rst_n), .de_memRead(de_memRead), .de_rd(de_rd),
    .fd_rs1(fd_rs1), .fd_rs2(fd_rs2), .fd_useRs1(fd_useRs1),
    .fd_useRs2(fd_useRs2), .ex_busy(ex_busy), .ex_takeBranch(ex_takeBranch),
    .stall(c_stall), .pcWrite(c_pc), .fdWrite(c_fd), .deWrite(c_de),
    .deBubble(c_bub), .fdFlush(c_ff), .deFlush(c_df),
    .perfStallCycles(c_perf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    de_memRead    = 1'b0;
    de_rd         = 5'd0;
    fd_rs1        = 5'd0;
    fd_rs2        = 5'd0;
    fd_useRs1     = 1'b0;
    fd_useRs2     = 1'b0;
    ex_busy       = 1'b0;
    ex_takeBranch = 1'b0;
  endtask

  task automatic set_hit5();
    de_memRead = 1'b1;
    de_rd      = 5'd5;
    fd_rs1     = 5'd5;
    fd_useRs1  = 1'b1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a_pc, a_fd, a_de} !== 3'b000) begin
      errors++;
      $display("FAIL rst_we: got %b want 000", {a_pc, a_fd, a_de});
    end
    checks++;
    if ({a_stall, a_bub, a_ff, a_df} !== 4'b0000) begin
      errors++;
      $display("FAIL rst_ctl: got %b want 0000", {a_stall, a_bub, a_ff, a_df});
    end
    checks++;
    if (a_perf !== 32'd0) begin
      errors++;
      $display("FAIL rst_perf: got %0d want 0", a_perf);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if ({a_pc, a_fd, a_de, a_stall} !== 4'b1110) begin
      errors++;
      $display("FAIL idle_out: got %b want 1110", {a_pc, a_fd, a_de, a_stall});
    end
  endtask

  task automatic test_single_bubble();
    do_reset();
    @(negedge clk);
    set_hit5();
    #1;
    checks++;
    if ({a_stall, a_pc, a_fd, a_de, a_bub} !== 5'b10011) begin
      errors++;
      $display("FAIL lat1_hit: got %b want 10011",
               {a_stall, a_pc, a_fd, a_de, a_bub});
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++;
    if ({a_stall, a_pc, a_bub} !== 3'b010) begin
      errors++;
      $display("FAIL lat1_next: got %b want 010", {a_stall, a_pc, a_bub});
    end
    checks++;
    if (a_perf !== 32'd1) begin
      errors++;
      $display("FAIL lat1_perf: got %0d want 1", a_perf);
    end
  endtask

  task automatic test_multi_bubble();
    do_reset();
    @(negedge clk);
    set_hit5();
    #1;
    checks++;
    if ({b_stall, b_pc, b_bub} !== 3'b101) begin
      errors++;
      $display("FAIL lat3_c0: got %b want 101", {b_stall, b_pc, b_bub});
    end
    for (int i = 1; i < 3; i++) begin
      @(negedge clk);
      clear_inputs();
      #1;
      checks++;
      if ({b_stall, b_pc, b_fd, b_de, b_bub} !== 5'b10011) begin
        errors++;
        $display("FAIL lat3_c%0d: got %b want 10011", i,
                 {b_stall, b_pc, b_fd, b_de, b_bub});
      end
    end
    @(negedge clk);
    #1;
    checks++;
    if ({b_stall, b_pc, b_bub} !== 3'b010) begin
      errors++;
      $display("FAIL lat3_rel: got %b want 010", {b_stall, b_pc, b_bub});
    end
    checks++;
    if (b_perf !== 32'd3) begin
      errors++;
      $display("FAIL lat3_perf: got %0d want 3", b_perf);
    end
  endtask

  task automatic test_filter();
    do_reset();
    @(negedge clk);
    de_memRead = 1'b1;
    fd_useRs1  = 1'b1;
    #1;
    checks++;
    if ({a_stall, b_stall} !== 2'b00) begin
      errors++;
      $display("FAIL x0_hit: got %b want 00", {a_stall, b_stall});
    end
    de_rd     = 5'd7;
    fd_rs1    = 5'd3;
    fd_rs2    = 5'd7;
    fd_useRs2 = 1'b0;
    #1;
    checks++;
    if ({a_stall, b_stall} !== 2'b00) begin
      errors++;
      $display("FAIL rs2_unused: got %b want 00", {a_stall, b_stall});
    end
    fd_useRs2 = 1'b1;
    #1;
    checks++;
    if ({a_stall, a_pc, a_bub} !== 3'b101) begin
      errors++;
      $display("FAIL rs2_used: got %b want 101", {a_stall, a_pc, a_bub});
    end
    de_memRead = 1'b0;
    #1;
    checks++;
    if (a_stall !== 1'b0) begin
      errors++;
      $display("FAIL no_load: got %b want 0", a_stall);
    end
  endtask

  task automatic test_branch_abort();
    do_reset();
    @(negedge clk);
    set_hit5();
    @(negedge clk);
    clear_inputs();
    ex_takeBranch = 1'b1;
    #1;
    checks++;
    if ({b_ff, b_df, b_pc, b_fd, b_de, b_stall, b_bub} !== 7'b1111100) begin
      errors++;
      $display("FAIL br_flush: got %b want 1111100",
               {b_ff, b_df, b_pc, b_fd, b_de, b_stall, b_bub});
    end
    @(negedge clk);
    ex_takeBranch = 1'b0;
    #1;
    checks++;
    if ({b_stall, b_pc, b_ff} !== 3'b010) begin
      errors++;
      $display("FAIL br_after: got %b want 010", {b_stall, b_pc, b_ff});
    end
    @(negedge clk);
    #1;
    checks++;
    if ((b_stall !== 1'b0) || (b_perf !== 32'd1)) begin
      errors++;
      $display("FAIL br_idle: got stall=%b perf=%0d want 0/1", b_stall, b_perf);
    end
  endtask

  task automatic test_busy_freeze();
    do_reset();
    @(negedge clk);
    set_hit5();
    @(negedge clk);
    clear_inputs();
    ex_busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++;
      if ({b_stall, b_pc, b_fd, b_de, b_bub, b_ff} !== 6'b100000) begin
        errors++;
        $display("FAIL busy_c%0d: got %b want 100000", i,
                 {b_stall, b_pc, b_fd, b_de, b_bub, b_ff});
      end
      @(negedge clk);
    end
    ex_busy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if ({b_stall, b_pc, b_de, b_bub} !== 4'b1011) begin
        errors++;
        $display("FAIL resume_c%0d: got %b want 1011", i,
                 {b_stall, b_pc, b_de, b_bub});
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if ((b_stall !== 1'b0) || (b_perf !== 32'd7)) begin
      errors++;
      $display("FAIL busy_end: got stall=%b perf=%0d want 0/7", b_stall, b_perf);
    end
  endtask

  task automatic test_saturate_reset();
    do_reset();
    @(negedge clk);
    set_hit5();
    repeat (14) @(negedge clk);
    #1;
    checks++;
    if (c_perf !== 4'd14) begin
      errors++;
      $display("FAIL perf_14: got %0d want 14", c_perf);
    end
    repeat (6) @(negedge clk);
    #1;
    checks++;
    if (c_perf !== 4'd15) begin
      errors++;
      $display("FAIL perf_sat: got %0d want 15", c_perf);
    end
    checks++;
    if (b_stall !== 1'b1) begin
      errors++;
      $display("FAIL pre_rst_stall: got %b want 1", b_stall);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({c_stall, c_pc, c_fd, c_de, c_bub, c_ff, c_df} !== 7'b0) begin
      errors++;
      $display("FAIL rst_mid: got %b want 0000000",
               {c_stall, c_pc, c_fd, c_de, c_bub, c_ff, c_df});
    end
    checks++;
    if ((c_perf !== 4'd0) || (b_stall !== 1'b0)) begin
      errors++;
      $display("FAIL rst_clr: got perf=%0d stall=%b want 0/0", c_perf, b_stall);
    end
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({b_stall, b_pc, c_stall, c_pc} !== 4'b0101) begin
      errors++;
      $display("FAIL post_rst: got %b want 0101",
               {b_stall, b_pc, c_stall, c_pc});
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    clear_inputs();
    test_reset();
    test_single_bubble();
    test_multi_bubble();
    test_filter();
    test_branch_abort();
    test_busy_freeze();
    test_saturate_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
